cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception/interrupt controller in the M stage.
- Collects exception codes and the branch-delay flag carried down the pipeline registers, plus external hardware interrupts.
- Produces the single `req` flush/redirect strobe that every pipeline register consumes to load a bubble and the handler PC 0x0000_4180.
- Holds SR/Cause/EPC/PRId for mfc0/mtc0/eret.

---
 rtl/cp0_exc_ctrl_if.sv | 29 ++
 rtl/cp0_exc_ctrl.sv | 110 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: groups the CP0 exception controller's pipeline-facing signals.
//   master: the M stage / pipeline side. It drives the mfc0/mtc0 access, PC, bd,
//           exception code, interrupt lines and eret, and receives the results.
//   slave : cp0_exc_ctrl. It returns rd_data, epc_out, req and handler_pc.
interface cp0_exc_ctrl_if;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] rd_data;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] handler_pc;

    modport master (
        output rd_addr, wr_addr, wr_data, wr_en, pc_in, bd_in, exc_code_in, hw_int, exl_clr,
        input  rd_data, epc_out, req, handler_pc
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en, pc_in, bd_in, exc_code_in, hw_int, exl_clr,
        output rd_data, epc_out, req, handler_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller in the M stage.
// It holds SR(12), Cause(13), EPC(14) and PRId(15), serves mfc0 reads and mtc0
// writes, and raises the combinational req flush/redirect strobe.
// Ports:
//   clk   - system clock; all state changes on its rising edge
//   reset - asynchronous, active-low reset
//   bus   - cp0_exc_ctrl_if.slave, which carries:
//             rd_addr, wr_addr, wr_data, wr_en, pc_in, bd_in, exc_code_in,
//             hw_int, exl_clr in; rd_data, epc_out, req, handler_pc out
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = 32'h2023_0701,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          reset,
    cp0_exc_ctrl_if.slave bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        req_int;

    // Gating with reset keeps req low while reset is held, even when a stray
    // exception code is still present on the input.
    assign int_req = reset & ie_q & ~exl_q & (|(bus.hw_int & im_q));
    assign exc_req = reset & ~exl_q & (bus.exc_code_in != 5'd0);
    assign req_int = int_req | exc_req;

    assign bus.req        = req_int;
    assign bus.epc_out    = epc_q;
    assign bus.handler_pc = HANDLER_PC;

    // mfc0 read: combinational, showing register contents before the edge.
    always_comb begin
        bus.rd_data = 32'd0;
        case (bus.rd_addr)
            ADDR_SR:    bus.rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
            ADDR_CAUSE: bus.rd_data = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            ADDR_EPC:   bus.rd_data = epc_q;
            ADDR_PRID:  bus.rd_data = PRID;
            default:    bus.rd_data = 32'd0;
        endcase
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = bus.hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (req_int) begin
            // The faulting instruction does not commit, so any mtc0 is dropped.
            exl_d      = 1'b1;
            bd_d       = bus.bd_in;
            exc_code_d = int_req ? 5'd0 : bus.exc_code_in;
            epc_d      = bus.bd_in ? (bus.pc_in - 32'd4) : bus.pc_in;
        end else begin
            if (bus.wr_en && (bus.wr_addr == ADDR_SR)) begin
                im_d  = bus.wr_data[15:10];
                exl_d = bus.wr_data[1];
                ie_d  = bus.wr_data[0];
            end
            if (bus.wr_en && !bus.exl_clr && (bus.wr_addr == ADDR_EPC)) begin
                epc_d = bus.wr_data;
            end
            // eret overrides a concurrent SR write for EXL only.
            if (bus.exl_clr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl. Stimulus pushes the expected observations for the
// current cycle into a queue, and a monitor pops and compares them on the
// falling clock edge.
module tb_cp0_exc_ctrl;
    localparam logic [31:0] PRID       = 32'h2023_0701;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [1:0] K_REQ = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_EPC = 2'd2;
    localparam logic [1:0] K_HPC = 2'd3;

    typedef struct packed {
        int          cyc;
        logic [1:0]  kind;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    exp_t        exp_q[$];
    string       name_q[$];
    exp_t        e;
    string       nm;
    logic [31:0] act;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(
        .PRID       (PRID),
        .HANDLER_PC (HANDLER_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input logic [1:0] k, input logic [31:0] v, input string n);
        exp_t x;
        x.cyc  = cyc;
        x.kind = k;
        x.val  = v;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    // Monitor: compares the DUT against every expectation that is due this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e.kind)
                K_REQ:   act = {31'd0, bus.req};
                K_RD:    act = bus.rd_data;
                K_EPC:   act = bus.epc_out;
                default: act = bus.handler_pc;
            endcase
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: check missed (due cycle %0d, now %0d)", nm, e.cyc, cyc);
            end else if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h, want %h", nm, act, e.val);
            end
        end
    end

    initial begin
        logic [4:0] addrs [5];
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.rd_addr     = 5'd0;
        bus.wr_addr     = 5'd0;
        bus.wr_data     = 32'd0;
        bus.wr_en       = 1'b0;
        bus.pc_in       = 32'd0;
        bus.bd_in       = 1'b0;
        bus.exc_code_in = 5'd0;
        bus.hw_int      = 6'd0;
        bus.exl_clr     = 1'b0;

        // 1. Reset, then basic read/write.
        tick();
        bus.rd_addr = 5'd12;
        expect_sig(K_RD, 32'd0, "rst_sr");
        expect_sig(K_REQ, 32'd0, "rst_req");
        expect_sig(K_EPC, 32'd0, "rst_epc");
        expect_sig(K_HPC, HANDLER_PC, "handler_pc");
        tick();
        reset = 1'b1;
        addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.rd_addr = addrs[i];
            expect_sig(K_RD, (addrs[i] == 5'd15) ? PRID : 32'd0, "post_rst_read");
        end
        tick();
        bus.rd_addr = 5'd12;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd12;
        bus.wr_data = 32'h0000_FC01;
        expect_sig(K_RD, 32'd0, "sr_no_writethrough");
        tick();
        bus.wr_addr = 5'd14;
        bus.wr_data = 32'h0000_3008;
        expect_sig(K_RD, 32'h0000_FC01, "sr_written");
        tick();
        bus.wr_en = 1'b0;
        expect_sig(K_EPC, 32'h0000_3008, "epc_written");

        // 2. Exception, not in a delay slot.
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd12;
        bus.wr_data = 32'h0000_0001;
        tick();
        bus.wr_en       = 1'b0;
        bus.exc_code_in = 5'd10;
        bus.pc_in       = 32'h0000_3010;
        bus.bd_in       = 1'b0;
        expect_sig(K_REQ, 32'd1, "exc_req");
        tick();
        bus.rd_addr = 5'd13;
        expect_sig(K_REQ, 32'd0, "exl_blocks_req");
        expect_sig(K_EPC, 32'h0000_3010, "exc_epc");
        expect_sig(K_RD, 32'h0000_0028, "exc_cause");
        tick();
        bus.rd_addr = 5'd12;
        expect_sig(K_RD, 32'h0000_0003, "exc_sr_exl");
        expect_sig(K_REQ, 32'd0, "exl_blocks_req2");

        // 3. Delay-slot exception with a concurrent mtc0 to EPC.
        tick();
        bus.exc_code_in = 5'd0;
        bus.exl_clr     = 1'b1;
        tick();
        bus.exl_clr = 1'b0;
        expect_sig(K_RD, 32'h0000_0001, "eret_sr");
        tick();
        bus.bd_in       = 1'b1;
        bus.pc_in       = 32'h0000_3020;
        bus.exc_code_in = 5'd12;
        bus.wr_en       = 1'b1;
        bus.wr_addr     = 5'd14;
        bus.wr_data     = 32'hDEAD_BEEF;
        expect_sig(K_REQ, 32'd1, "bd_req");
        tick();
        bus.wr_en       = 1'b0;
        bus.exc_code_in = 5'd0;
        bus.bd_in       = 1'b0;
        bus.rd_addr     = 5'd13;
        expect_sig(K_EPC, 32'h0000_301C, "bd_epc");
        expect_sig(K_RD, 32'h8000_0030, "bd_cause");

        // 4. Interrupt priority and masking. eret together with an SR write:
        // EXL clears, IM/IE take the data.
        tick();
        bus.exl_clr = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd12;
        bus.wr_data = 32'h0000_0403;
        tick();
        bus.exl_clr = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_addr = 5'd12;
        expect_sig(K_RD, 32'h0000_0401, "eret_vs_mtc0_sr");
        tick();
        bus.hw_int      = 6'b000001;
        bus.exc_code_in = 5'd4;
        bus.pc_in       = 32'h0000_3040;
        expect_sig(K_REQ, 32'd1, "int_req");
        tick();
        bus.hw_int      = 6'd0;
        bus.exc_code_in = 5'd0;
        bus.rd_addr     = 5'd13;
        expect_sig(K_RD, 32'h0000_0400, "int_cause_code0");
        expect_sig(K_EPC, 32'h0000_3040, "int_epc");
        tick();
        bus.exl_clr = 1'b1;
        tick();
        bus.exl_clr = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd12;
        bus.wr_data = 32'h0000_0001;
        tick();
        bus.wr_en  = 1'b0;
        bus.hw_int = 6'b000001;
        expect_sig(K_REQ, 32'd0, "im0_masked");
        tick();
        bus.rd_addr = 5'd13;
        expect_sig(K_RD, 32'h0000_0400, "masked_ip_follows");
        expect_sig(K_REQ, 32'd0, "im0_masked2");
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h0000_0400;
        tick();
        bus.wr_en  = 1'b0;
        bus.hw_int = 6'b100011;
        expect_sig(K_REQ, 32'd0, "ie0_masked");
        tick();
        expect_sig(K_RD, 32'h0000_8C00, "ie0_ip_follows");

        // 5. eret re-arms a pending interrupt.
        tick();
        bus.hw_int  = 6'b000001;
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'h0000_0401;
        tick();
        bus.wr_en = 1'b0;
        bus.pc_in = 32'h0000_3050;
        expect_sig(K_REQ, 32'd1, "rearm_first_int");
        tick();
        bus.exl_clr = 1'b1;
        expect_sig(K_REQ, 32'd0, "in_handler_no_req");
        tick();
        bus.exl_clr = 1'b0;
        bus.pc_in   = 32'h0000_3060;
        expect_sig(K_REQ, 32'd1, "rearm_after_eret");
        tick();
        bus.hw_int = 6'd0;
        expect_sig(K_EPC, 32'h0000_3060, "rearm_epc");

        // 6. Asynchronous reset in the middle of the handler.
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd14;
        bus.wr_data = 32'h0000_3010;
        tick();
        bus.wr_en   = 1'b0;
        bus.rd_addr = 5'd12;
        expect_sig(K_EPC, 32'h0000_3010, "pre_rst_epc");
        expect_sig(K_RD, 32'h0000_0403, "pre_rst_sr");
        tick();
        reset           = 1'b0;
        bus.exc_code_in = 5'd7;
        expect_sig(K_RD, 32'd0, "async_rst_sr");
        expect_sig(K_EPC, 32'd0, "async_rst_epc");
        expect_sig(K_REQ, 32'd0, "async_rst_req");
        tick();
        bus.rd_addr = 5'd13;
        expect_sig(K_RD, 32'd0, "async_rst_cause");

        // Delay-slot EPC wraps around below address zero.
        tick();
        reset           = 1'b1;
        bus.exc_code_in = 5'd0;
        tick();
        bus.bd_in       = 1'b1;
        bus.pc_in       = 32'd0;
        bus.exc_code_in = 5'd4;
        expect_sig(K_REQ, 32'd1, "wrap_req");
        tick();
        bus.bd_in       = 1'b0;
        bus.exc_code_in = 5'd0;
        expect_sig(K_EPC, 32'hFFFF_FFFC, "wrap_epc");

        tick();
        tick();
        if (exp_q.size() > 0) begin
            $display("FAIL leftover: %0d checks never compared, want 0", exp_q.size());
            bad += exp_q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
